// File: rtl/snake_vram_arbiter_if.sv
// rtl/snake_vram_arbiter_if.sv - client, pixel-fetch, clear and VRAM signals of the VRAM arbiter
interface snake_vram_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 4
);
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_valid;
  logic [DATA_W-1:0] vga_q;

  logic              c0_req;
  logic              c0_we;
  logic [ADDR_W-1:0] c0_addr;
  logic [DATA_W-1:0] c0_wdata;
  logic              c0_gnt;
  logic              c0_rvalid;
  logic [DATA_W-1:0] c0_rdata;

  logic              c1_req;
  logic              c1_we;
  logic [ADDR_W-1:0] c1_addr;
  logic [DATA_W-1:0] c1_wdata;
  logic              c1_gnt;
  logic              c1_rvalid;
  logic [DATA_W-1:0] c1_rdata;

  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;

  logic [ADDR_W-1:0] mem_raddr;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  vga_req, vga_addr,
    output vga_valid, vga_q,
    input  c0_req, c0_we, c0_addr, c0_wdata,
    output c0_gnt, c0_rvalid, c0_rdata,
    input  c1_req, c1_we, c1_addr, c1_wdata,
    output c1_gnt, c1_rvalid, c1_rdata,
    input  clr_start,
    output clr_busy, clr_done,
    output mem_raddr, mem_waddr, mem_wdata, mem_wren,
    input  mem_q
  );

  modport master (
    output vga_req, vga_addr,
    input  vga_valid, vga_q,
    output c0_req, c0_we, c0_addr, c0_wdata,
    input  c0_gnt, c0_rvalid, c0_rdata,
    output c1_req, c1_we, c1_addr, c1_wdata,
    input  c1_gnt, c1_rvalid, c1_rdata,
    output clr_start,
    input  clr_busy, clr_done,
    input  mem_raddr, mem_waddr, mem_wdata, mem_wren,
    output mem_q
  );
endinterface

// File: rtl/snake_vram_arbiter.sv
// rtl/snake_vram_arbiter.sv - VRAM read/write port arbiter with tagged read return and screen-clear sequencer
module snake_vram_arbiter #(
  parameter int                ADDR_W   = 9,
  parameter int                DATA_W   = 4,
  parameter int                RD_LAT   = 2,
  parameter int                CELLS    = 475,
  parameter logic [DATA_W-1:0] CLR_DATA = '0
) (
  input logic                 clk,
  input logic                 rst,
  snake_vram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_C0, TAG_C1} tag_t;
  typedef enum logic [1:0] {CLR_IDLE, CLR_RUN, CLR_LAST} clr_state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

  clr_state_t        r_clr_state, w_clr_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr, w_clr_addr_nxt, w_clr_waddr;
  logic              r_clr_done, w_clr_done_nxt, w_clr_issue, w_clr_busy;

  logic              r_c0_gnt, r_c1_gnt, r_rd_last, r_wr_last, r_wren;
  logic [ADDR_W-1:0] r_raddr, r_waddr;
  logic [DATA_W-1:0] r_wdata;
  tag_t              r_tag [RD_LAT+1];

  logic              w_c0_rd, w_c1_rd, w_c0_wr, w_c1_wr;
  logic              w_c0_rd_gnt, w_c1_rd_gnt, w_c0_wr_gnt, w_c1_wr_gnt;
  logic [ADDR_W-1:0] w_raddr, w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_wr_issue;
  tag_t              w_rd_tag;

  // A client is deaf in its grant cycle so a held request is not granted twice.
  assign w_c0_rd = bus.c0_req & ~bus.c0_we & ~r_c0_gnt;
  assign w_c1_rd = bus.c1_req & ~bus.c1_we & ~r_c1_gnt;
  assign w_c0_wr = bus.c0_req &  bus.c0_we & ~r_c0_gnt;
  assign w_c1_wr = bus.c1_req &  bus.c1_we & ~r_c1_gnt;

  assign w_clr_busy = (r_clr_state != CLR_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clr_state <= CLR_IDLE;
      r_clr_addr  <= '0;
      r_clr_done  <= 1'b0;
    end else begin
      r_clr_state <= w_clr_state_nxt;
      r_clr_addr  <= w_clr_addr_nxt;
      r_clr_done  <= w_clr_done_nxt;
    end
  end

  // The first clear write is issued straight from idle so writes start the cycle busy rises.
  always_comb begin
    w_clr_state_nxt = r_clr_state;
    w_clr_addr_nxt  = r_clr_addr;
    w_clr_waddr     = r_clr_addr;
    w_clr_issue     = 1'b0;
    w_clr_done_nxt  = 1'b0;
    case (r_clr_state)
      CLR_IDLE: begin
        if (bus.clr_start) begin
          w_clr_issue     = 1'b1;
          w_clr_waddr     = '0;
          w_clr_addr_nxt  = ADDR_W'(1);
          w_clr_state_nxt = CLR_RUN;
        end
      end
      CLR_RUN: begin
        w_clr_issue = 1'b1;
        if (r_clr_addr == LAST_ADDR) w_clr_state_nxt = CLR_LAST;
        else                         w_clr_addr_nxt  = r_clr_addr + ADDR_W'(1);
      end
      CLR_LAST: begin
        w_clr_state_nxt = CLR_IDLE;
        w_clr_done_nxt  = 1'b1;
      end
      default: w_clr_state_nxt = CLR_IDLE;
    endcase
  end

  always_comb begin
    w_c0_rd_gnt = 1'b0;
    w_c1_rd_gnt = 1'b0;
    w_raddr     = r_raddr;
    w_rd_tag    = TAG_NONE;
    if (bus.vga_req) begin
      w_raddr  = bus.vga_addr;
      w_rd_tag = TAG_VGA;
    end else if (w_c0_rd && (!w_c1_rd || r_rd_last)) begin
      w_c0_rd_gnt = 1'b1;
      w_raddr     = bus.c0_addr;
      w_rd_tag    = TAG_C0;
    end else if (w_c1_rd) begin
      w_c1_rd_gnt = 1'b1;
      w_raddr     = bus.c1_addr;
      w_rd_tag    = TAG_C1;
    end
  end

  always_comb begin
    w_c0_wr_gnt = 1'b0;
    w_c1_wr_gnt = 1'b0;
    w_wr_issue  = 1'b0;
    w_waddr     = r_waddr;
    w_wdata     = r_wdata;
    if (w_clr_issue) begin
      w_wr_issue = 1'b1;
      w_waddr    = w_clr_waddr;
      w_wdata    = CLR_DATA;
    end else if (!w_clr_busy) begin
      if (w_c0_wr && (!w_c1_wr || r_wr_last)) begin
        w_c0_wr_gnt = 1'b1;
        w_wr_issue  = 1'b1;
        w_waddr     = bus.c0_addr;
        w_wdata     = bus.c0_wdata;
      end else if (w_c1_wr) begin
        w_c1_wr_gnt = 1'b1;
        w_wr_issue  = 1'b1;
        w_waddr     = bus.c1_addr;
        w_wdata     = bus.c1_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_c0_gnt  <= 1'b0;
      r_c1_gnt  <= 1'b0;
      r_rd_last <= 1'b1;
      r_wr_last <= 1'b1;
      r_raddr   <= '0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_wren    <= 1'b0;
      for (int i = 0; i <= RD_LAT; i++) r_tag[i] <= TAG_NONE;
    end else begin
      r_c0_gnt <= w_c0_rd_gnt | w_c0_wr_gnt;
      r_c1_gnt <= w_c1_rd_gnt | w_c1_wr_gnt;
      if (w_c0_rd_gnt)      r_rd_last <= 1'b0;
      else if (w_c1_rd_gnt) r_rd_last <= 1'b1;
      if (w_c0_wr_gnt)      r_wr_last <= 1'b0;
      else if (w_c1_wr_gnt) r_wr_last <= 1'b1;
      r_raddr  <= w_raddr;
      r_waddr  <= w_waddr;
      r_wdata  <= w_wdata;
      r_wren   <= w_wr_issue;
      r_tag[0] <= w_rd_tag;
      for (int i = 1; i <= RD_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign bus.c0_gnt    = r_c0_gnt;
  assign bus.c1_gnt    = r_c1_gnt;
  assign bus.vga_valid = (r_tag[RD_LAT] == TAG_VGA);
  assign bus.c0_rvalid = (r_tag[RD_LAT] == TAG_C0);
  assign bus.c1_rvalid = (r_tag[RD_LAT] == TAG_C1);
  assign bus.vga_q     = bus.mem_q;
  assign bus.c0_rdata  = bus.mem_q;
  assign bus.c1_rdata  = bus.mem_q;
  assign bus.clr_busy  = w_clr_busy;
  assign bus.clr_done  = r_clr_done;
  assign bus.mem_raddr = r_raddr;
  assign bus.mem_waddr = r_waddr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_wren  = r_wren;
endmodule

// File: tb/tb_snake_vram_arbiter.sv
// tb/tb_snake_vram_arbiter.sv - directed self-checking bench for snake_vram_arbiter
module tb_snake_vram_arbiter;
  logic clk;
  logic rst;
  logic preload;
  int   n_checks;
  int   n_errors;

  logic [3:0] vram [0:511];
  logic [3:0] r_s1;

  snake_vram_arbiter_if #(.ADDR_W(9), .DATA_W(4)) bus ();

  snake_vram_arbiter #(
    .ADDR_W(9), .DATA_W(4), .RD_LAT(2), .CELLS(475), .CLR_DATA(4'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM model: two-cycle registered read, cell i holds i[3:0] except cell 37 = 3
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 512; i++) vram[i] <= (i == 37) ? 4'h3 : i[3:0];
    end else if (bus.mem_wren) begin
      vram[bus.mem_waddr] <= bus.mem_wdata;
    end
    r_s1       <= vram[bus.mem_raddr];
    bus.mem_q  <= r_s1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check(tag, {bus.c0_gnt, bus.c1_gnt, bus.c0_rvalid, bus.c1_rvalid, bus.vga_valid,
                bus.clr_busy, bus.clr_done, bus.mem_wren, bus.mem_raddr, bus.mem_waddr,
                bus.mem_wdata}, 32'h0);
  endtask

  task automatic set_c0(input logic req, input logic we, input logic [8:0] addr, input logic [3:0] wd);
    bus.c0_req = req; bus.c0_we = we; bus.c0_addr = addr; bus.c0_wdata = wd;
  endtask

  task automatic set_c1(input logic req, input logic we, input logic [8:0] addr, input logic [3:0] wd);
    bus.c1_req = req; bus.c1_we = we; bus.c1_addr = addr; bus.c1_wdata = wd;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    preload = 1'b1;
    bus.vga_req = 1'b0; bus.vga_addr = '0; bus.clr_start = 1'b0;
    set_c0(1'b0, 1'b0, 9'd0, 4'h0);
    set_c1(1'b0, 1'b0, 9'd0, 4'h0);
    tick(); tick();
    check_quiet("reset_state");
    preload = 1'b0;
    rst = 1'b1;
    tick();

    // single c0 read of cell 37
    set_c0(1'b1, 1'b0, 9'd37, 4'h0);
    tick();
    check("rd_c0_gnt", {bus.c0_gnt, bus.c1_gnt, bus.mem_raddr}, {2'b10, 9'd37});
    set_c0(1'b0, 1'b0, 9'd0, 4'h0);
    tick();
    check("rd_c0_early", bus.c0_rvalid, 1'b0);
    tick();
    check("rd_c0_data", {bus.c0_rvalid, bus.c0_rdata}, {1'b1, 4'h3});
    tick();
    check("rd_c0_pulse", bus.c0_rvalid, 1'b0);

    // vga_req blocks c1 read
    bus.vga_req = 1'b1; bus.vga_addr = 9'd5;
    set_c1(1'b1, 1'b0, 9'd100, 4'h0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("vga_blocks_c1", bus.c1_gnt, 1'b0);
      if (i >= 3) check("vga_data", {bus.vga_valid, bus.vga_q}, {1'b1, 4'h5});
    end
    bus.vga_req = 1'b0;
    tick();
    check("c1_gnt_after_vga", {bus.c1_gnt, bus.mem_raddr}, {1'b1, 9'd100});
    set_c1(1'b0, 1'b0, 9'd0, 4'h0);
    tick();
    check("c1_wait", {bus.c1_rvalid, bus.vga_valid}, 2'b01);
    tick();
    check("c1_data", {bus.c1_rvalid, bus.c1_rdata, bus.vga_valid}, {1'b1, 4'h4, 1'b0});

    // competing writes alternate, c0 first
    set_c0(1'b1, 1'b1, 9'd200, 4'h7);
    set_c1(1'b1, 1'b1, 9'd201, 4'h9);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i % 2 == 0)
        check("wr_rr_c0", {bus.c0_gnt, bus.c1_gnt, bus.mem_wren, bus.mem_waddr, bus.mem_wdata},
              {3'b101, 9'd200, 4'h7});
      else
        check("wr_rr_c1", {bus.c0_gnt, bus.c1_gnt, bus.mem_wren, bus.mem_waddr, bus.mem_wdata},
              {3'b011, 9'd201, 4'h9});
    end
    set_c0(1'b0, 1'b0, 9'd0, 4'h0);
    set_c1(1'b0, 1'b0, 9'd0, 4'h0);
    tick();
    check("wr_rr_idle", {bus.c0_gnt, bus.c1_gnt, bus.mem_wren}, 3'b000);

    // c0 write and c1 read in the same cycle
    set_c0(1'b1, 1'b1, 9'd300, 4'hA);
    set_c1(1'b1, 1'b0, 9'd37, 4'h0);
    tick();
    check("dual_port", {bus.c0_gnt, bus.c1_gnt, bus.mem_wren, bus.mem_waddr, bus.mem_wdata, bus.mem_raddr},
          {3'b111, 9'd300, 4'hA, 9'd37});
    set_c0(1'b0, 1'b0, 9'd0, 4'h0);
    set_c1(1'b0, 1'b0, 9'd0, 4'h0);
    tick(); tick();
    check("dual_rdata", {bus.c1_rvalid, bus.c1_rdata, bus.mem_wren}, {1'b1, 4'h3, 1'b0});

    // competing reads: c1 was last, so c0 first
    set_c0(1'b1, 1'b0, 9'd37, 4'h0);
    set_c1(1'b1, 1'b0, 9'd100, 4'h0);
    tick();
    check("rd_rr_c0", {bus.c0_gnt, bus.c1_gnt, bus.mem_raddr}, {2'b10, 9'd37});
    set_c0(1'b0, 1'b0, 9'd0, 4'h0);
    tick();
    check("rd_rr_c1", {bus.c0_gnt, bus.c1_gnt, bus.mem_raddr}, {2'b01, 9'd100});
    set_c1(1'b0, 1'b0, 9'd0, 4'h0);
    tick();
    check("rd_rr_c0_data", {bus.c0_rvalid, bus.c1_rvalid, bus.c0_rdata}, {2'b10, 4'h3});
    tick();
    check("rd_rr_c1_data", {bus.c0_rvalid, bus.c1_rvalid, bus.c1_rdata}, {2'b01, 4'h4});

    // read back the earlier c0 write
    set_c0(1'b1, 1'b0, 9'd300, 4'h0);
    tick();
    set_c0(1'b0, 1'b0, 9'd0, 4'h0);
    tick(); tick();
    check("readback_300", {bus.c0_rvalid, bus.c0_rdata}, {1'b1, 4'hA});
    tick();

    // screen clear with a pending c0 write and a second start mid-clear
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    set_c0(1'b1, 1'b1, 9'd10, 4'hF);
    for (int a = 0; a < 475; a++) begin
      check("clr_step", {bus.mem_wren, bus.mem_waddr, bus.mem_wdata, bus.c0_gnt, bus.clr_done, bus.clr_busy},
            {1'b1, 9'(a), 4'h0, 1'b0, 1'b0, 1'b1});
      bus.clr_start = (a == 200);
      tick();
    end
    check("clr_done", {bus.clr_done, bus.clr_busy, bus.mem_wren, bus.c0_gnt}, 4'b1000);
    tick();
    check("c0_after_clr", {bus.c0_gnt, bus.mem_wren, bus.mem_waddr, bus.mem_wdata, bus.clr_done},
          {2'b11, 9'd10, 4'hF, 1'b0});
    set_c0(1'b0, 1'b0, 9'd0, 4'h0);
    tick();
    check("clr_quiet", {bus.clr_done, bus.clr_busy, bus.mem_wren}, 3'b000);

    set_c1(1'b1, 1'b0, 9'd37, 4'h0);
    tick();
    set_c1(1'b0, 1'b0, 9'd0, 4'h0);
    tick(); tick();
    check("cleared_37", {bus.c1_rvalid, bus.c1_rdata}, {1'b1, 4'h0});
    tick();

    // reset with two reads in flight and a clear running
    set_c0(1'b1, 1'b0, 9'd37, 4'h0);
    bus.clr_start = 1'b1;
    tick();
    set_c0(1'b0, 1'b0, 9'd0, 4'h0);
    bus.clr_start = 1'b0;
    set_c1(1'b1, 1'b0, 9'd100, 4'h0);
    tick();
    check("pre_rst_busy", {bus.c1_gnt, bus.clr_busy}, 2'b11);
    set_c1(1'b0, 1'b0, 9'd0, 4'h0);
    rst = 1'b0;
    #1;
    check_quiet("async_rst");
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_quiet("post_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
